sisc_ctrl_p: RTL
================

Name: sisc_ctrl_p

Overview:
- Parametrised successor to the SISC control FSM.
- Sequences fetch/decode/execute/mem/writeback and drives every datapath control for parts 2-4: PC update, branches, data-memory handshake, register-file writeback and status-register enable.
- Replaces simulation-only halting with a synthesizable HALT state.
- Adds a bounded memory-wait handshake with timeout and a retired-instruction counter.
- Sits between the instruction register / status register and the datapath.

Parameters:
- OP_W, 4, opcode width.
- STAT_W, 4, status flag width; also the width of the mm condition mask.
- ALU_OP_W, 2, ALU op-select width. Must be at least 2.
- MEM_TIMEOUT, 8, maximum cycles spent in MEM waiting for mem_rdy. Range 1..255.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- opcode  in  OP_W  current instruction opcode
- mm  in  STAT_W  addressing mode / branch condition mask
- stat  in  STAT_W  status register flags
- mem_rdy  in  1  data memory has completed the current request
- ir_load  out  1  load instruction register
- pc_write  out  1  PC register write enable
- pc_sel  out  1  0 = PC+1, 1 = branch target
- br_sel  out  1  0 = absolute target, 1 = PC-relative target
- stat_en  out  1  status register write enable
- alu_op  out  ALU_OP_W  ALU operation select
- mem_req  out  1  data memory request
- dm_we  out  1  data memory write enable
- rf_we  out  1  register file write enable
- wb_sel  out  1  0 = ALU result, 1 = memory data
- halted  out  1  core is in HALT
- mem_err  out  1  sticky flag: a memory timeout has occurred
- instr_count  out  CNT_W  retired-instruction count, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. While rst is high, state = START1, counters = 0, mem_err = 0.
- Outputs: all control outputs are decoded combinationally from the registered state plus the inputs.
  - Default values: all 0, except alu_op = 2'b10 (pass/add default).
  - The defaults are also the values during reset.
- State transitions:
  - START1 -> FETCH.
  - FETCH: ir_load = 1, pc_write = 1, pc_sel = 0. Next state DECODE.
  - DECODE, opcode == HLT (15): next state HALT.
  - DECODE, branch taken: pc_write = 1, pc_sel = 1; br_sel = 1 for BRR/BNR, 0 for BRA/BNE. Next state EXECUTE.
  - DECODE, all other cases: next state EXECUTE.
- Branch condition:
  - BRA/BRR are taken when (mm & stat) != 0.
  - BNE/BNR are taken when (mm & stat) == 0.
  - mm == 0 with BRA/BRR is never taken; mm == 0 with BNE/BNR is always taken.
- EXECUTE:
  - alu_op[1] = (opcode != ALU_OP); alu_op[0] = (mm == AM_IMM, 8). Upper alu_op bits are 0.
  - stat_en = 1 only for ALU_OP.
  - Next state MEM.
- MEM, LOD/STR:
  - mem_req = 1; dm_we = 1 for STR only.
  - A wait counter starts at 0 on MEM entry.
  - mem_rdy high -> WRITEBACK in the same cycle.
  - Counter reaches MEM_TIMEOUT-1 without mem_rdy -> WRITEBACK, set mem_err, and suppress rf_we for this instruction.
- MEM, all other opcodes: single cycle, no request.
- WRITEBACK:
  - rf_we = 1 for ALU_OP, LOD and SWP, unless the memory access timed out.
  - wb_sel = 1 for LOD.
  - Next state FETCH; instr_count increments here.
- instr_count saturates at all-ones; it does not wrap.
- HALT: halted = 1, all other controls at defaults. Absorbing; left only via rst.
- NOOP and undefined opcodes: traverse every state with no enables asserted.
- Reset mid-operation: any state returns to START1 immediately. Memory outputs drop asynchronously and a partial wait is discarded.
- mem_rdy sampled outside MEM is ignored.
- Nominal latency: 5 cycles per instruction (FETCH to WRITEBACK) plus memory wait cycles.

Decomposition:
- Package sisc_pkg holds:
  - the state encoding: START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT;
  - opcode constants: NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU_OP=8, HLT=15;
  - AM_IMM=8;
  - the default alu_op value.
- One sub-module, sisc_br_cond: combinational branch-taken evaluator over opcode, mm and stat. It outputs taken and relative.

Test Plan:
- Reset asserted mid-MEM with mem_req high -> mem_req drops without waiting for a clock; after release, sequence START1 -> FETCH, counters 0.
- ALU_OP, mm=8 -> EXECUTE alu_op=2'b01 with stat_en=1; WRITEBACK rf_we=1, wb_sel=0; instr_count goes 0 -> 1.
- BRR, mm=4'b0010, stat=4'b0010 -> DECODE pc_write=1, pc_sel=1, br_sel=1. Repeat with stat=0 -> pc_write=0 in DECODE.
- LOD with mem_rdy delayed 3 cycles, MEM_TIMEOUT=8 -> mem_req held for 4 cycles, then WRITEBACK rf_we=1, wb_sel=1, mem_err=0.
- STR with mem_rdy never asserted, MEM_TIMEOUT=8 -> exactly 8 MEM cycles with dm_we=1; mem_err then stays 1 until reset.
- HLT -> halted=1 from the cycle after DECODE, held for 100 cycles; instr_count frozen. CNT_W=4 run of 20 NOOPs -> instr_count saturates at 15.

Source files
------------

// File: rtl/sisc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sisc_pkg
// Description : Shared state encoding, opcode map and ALU defaults for the
//               SISC control path.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package sisc_pkg;

    typedef enum logic [2:0] {
        START1    = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEM       = 3'd4,
        WRITEBACK = 3'd5,
        HALT      = 3'd6
    } state_t;

    localparam logic [3:0] NOOP   = 4'd0;
    localparam logic [3:0] LOD    = 4'd1;
    localparam logic [3:0] STR    = 4'd2;
    localparam logic [3:0] SWP    = 4'd3;
    localparam logic [3:0] BRA    = 4'd4;
    localparam logic [3:0] BRR    = 4'd5;
    localparam logic [3:0] BNE    = 4'd6;
    localparam logic [3:0] BNR    = 4'd7;
    localparam logic [3:0] ALU_OP = 4'd8;
    localparam logic [3:0] HLT    = 4'd15;

    localparam logic [3:0] AM_IMM  = 4'd8;
    localparam logic [1:0] ALU_DEF = 2'b10;

endpackage
`default_nettype wire

// File: rtl/sisc_br_cond.sv
`default_nettype none
// ============================================================================
// Module      : sisc_br_cond
// Description : Combinational branch-taken evaluator over opcode, mode mask
//               and status flags.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module sisc_br_cond
    import sisc_pkg::*;
#(
    parameter int OP_W   = 4,
    parameter int STAT_W = 4
) (
    input  logic [OP_W-1:0]   opcode,
    input  logic [STAT_W-1:0] mm,
    input  logic [STAT_W-1:0] stat,
    output logic              taken,
    output logic              relative
);

    logic w_hit;
    logic w_on_set;
    logic w_on_clear;

    // An empty mask never hits, so BRA/BRR fall through and BNE/BNR always go
    assign w_hit      = |(mm & stat);
    assign w_on_set   = (opcode == OP_W'(BRA)) || (opcode == OP_W'(BRR));
    assign w_on_clear = (opcode == OP_W'(BNE)) || (opcode == OP_W'(BNR));
    assign taken      = (w_on_set && w_hit) || (w_on_clear && !w_hit);
    assign relative   = (opcode == OP_W'(BRR)) || (opcode == OP_W'(BNR));

endmodule
`default_nettype wire

// File: rtl/sisc_ctrl_p.sv
`default_nettype none
// ============================================================================
// Module      : sisc_ctrl_p
// Description : SISC control FSM - fetch/decode/execute/mem/writeback
//               sequencing, bounded memory wait, halt and retire counter.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module sisc_ctrl_p
    import sisc_pkg::*;
#(
    parameter int OP_W        = 4,
    parameter int STAT_W      = 4,
    parameter int ALU_OP_W    = 2,
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_W-1:0]     opcode,
    input  logic [STAT_W-1:0]   mm,
    input  logic [STAT_W-1:0]   stat,
    input  logic                mem_rdy,
    output logic                ir_load,
    output logic                pc_write,
    output logic                pc_sel,
    output logic                br_sel,
    output logic                stat_en,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                mem_req,
    output logic                dm_we,
    output logic                rf_we,
    output logic                wb_sel,
    output logic                halted,
    output logic                mem_err,
    output logic [CNT_W-1:0]    instr_count
);

    localparam logic [7:0] c_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           r_state;
    logic [7:0]       r_wait;
    logic             r_timeout;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_count;

    logic w_taken;
    logic w_relative;
    logic w_is_mem;

    sisc_br_cond #(
        .OP_W   (OP_W),
        .STAT_W (STAT_W)
    ) u_br_cond (
        .opcode   (opcode),
        .mm       (mm),
        .stat     (stat),
        .taken    (w_taken),
        .relative (w_relative)
    );

    assign w_is_mem    = (opcode == OP_W'(LOD)) || (opcode == OP_W'(STR));
    assign mem_err     = r_mem_err;
    assign instr_count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= START1;
            r_wait    <= 8'd0;
            r_timeout <= 1'b0;
            r_mem_err <= 1'b0;
            r_count   <= '0;
        end else begin
            case (r_state)
                START1:  r_state <= FETCH;
                FETCH: begin
                    r_state   <= DECODE;
                    r_timeout <= 1'b0;
                end
                DECODE:  r_state <= (opcode == OP_W'(HLT)) ? HALT : EXECUTE;
                EXECUTE: begin
                    r_state <= MEM;
                    r_wait  <= 8'd0;
                end
                MEM: begin
                    // A ready on the final permitted cycle still counts as success
                    if (!w_is_mem || mem_rdy) begin
                        r_state <= WRITEBACK;
                    end else if (r_wait == c_WAIT_LAST) begin
                        r_state   <= WRITEBACK;
                        r_timeout <= 1'b1;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                WRITEBACK: begin
                    r_state <= FETCH;
                    if (r_count != '1) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                HALT:    r_state <= HALT;
                default: r_state <= START1;
            endcase
        end
    end

    always_comb begin
        ir_load  = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        stat_en  = 1'b0;
        alu_op   = ALU_OP_W'(ALU_DEF);
        mem_req  = 1'b0;
        dm_we    = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        halted   = 1'b0;
        case (r_state)
            FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
            end
            DECODE: begin
                if (w_taken) begin
                    pc_write = 1'b1;
                    pc_sel   = 1'b1;
                    br_sel   = w_relative;
                end
            end
            EXECUTE: begin
                alu_op    = '0;
                alu_op[1] = (opcode != OP_W'(ALU_OP));
                alu_op[0] = (mm == STAT_W'(AM_IMM));
                stat_en   = (opcode == OP_W'(ALU_OP));
            end
            MEM: begin
                mem_req = w_is_mem;
                dm_we   = (opcode == OP_W'(STR));
            end
            WRITEBACK: begin
                rf_we  = ((opcode == OP_W'(ALU_OP)) || (opcode == OP_W'(LOD)) ||
                          (opcode == OP_W'(SWP))) && !r_timeout;
                wb_sel = (opcode == OP_W'(LOD));
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire
